// File: rtl/mux2to1_sel.sv
// Two-input selector with a purely combinational data path, a registered
// output tap and saturating sel-usage counters for debug visibility.
module mux2to1_sel #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [CNT_W-1:0] sel_toggles,
  output logic [CNT_W-1:0] b_cycles
);

  localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

  // Clear wins over increment; the count parks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_next(
    input logic [CNT_W-1:0] cnt,
    input logic             inc,
    input logic             clear
  );
    logic [CNT_W-1:0] res;
    res = cnt;
    if (clear) begin
      res = CNT_ZERO;
    end else if (inc && (cnt != CNT_MAX)) begin
      res = cnt + CNT_ONE;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  logic             sel_r;
  logic [WIDTH-1:0] out_q_r;
  logic [CNT_W-1:0] sel_toggles_r;
  logic [CNT_W-1:0] b_cycles_r;
  logic             toggle_s;
  logic [CNT_W-1:0] sel_toggles_nxt_s;
  logic [CNT_W-1:0] b_cycles_nxt_s;

  // Data path: no clock, reset or clear involvement, X passes straight through.
  assign out = sel ? b : a;

  // Next-state values for the monitor counters.
  always_comb begin
    toggle_s          = 1'b0;
    sel_toggles_nxt_s = sel_toggles_r;
    b_cycles_nxt_s    = b_cycles_r;
    toggle_s          = sel ^ sel_r;
    sel_toggles_nxt_s = sat_next(sel_toggles_r, toggle_s, clr);
    b_cycles_nxt_s    = sat_next(b_cycles_r, sel, clr);
  end

  // Monitor state: registered tap, previous select and the two counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r         <= 1'b0;
      out_q_r       <= DATA_ZERO;
      sel_toggles_r <= CNT_ZERO;
      b_cycles_r    <= CNT_ZERO;
    end else begin
      // sel_r keeps tracking through a clear so the next toggle is still seen
      sel_r         <= sel;
      out_q_r       <= out;
      sel_toggles_r <= sel_toggles_nxt_s;
      b_cycles_r    <= b_cycles_nxt_s;
    end
  end

  assign out_q       = out_q_r;
  assign sel_toggles = sel_toggles_r;
  assign b_cycles    = b_cycles_r;

endmodule

// File: tb/tb_mux2to1_sel.sv
// Self-checking bench for mux2to1_sel: truth-table vectors, scoreboarded
// monitor outputs, and directed corner sequences (tap, counters, saturation, reset).
module tb_mux2to1_sel;

  localparam int WIDTH = 1;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = 4'hF;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic             clr;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic [CNT_W-1:0] sel_toggles;
  logic [CNT_W-1:0] b_cycles;

  typedef struct {
    logic [WIDTH-1:0] out_q;
    logic [CNT_W-1:0] tog;
    logic [CNT_W-1:0] bc;
  } sb_rec_t;

  typedef struct {
    logic a;
    logic b;
    logic sel;
    logic exp_out;
  } tt_vec_t;

  sb_rec_t          sb_q[$];
  tt_vec_t          tt[10];
  int               checks;
  int               failures;
  logic             m_selq;
  logic [CNT_W-1:0] m_tog;
  logic [CNT_W-1:0] m_bc;
  logic [4:0]       pat;

  mux2to1_sel #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .clr(clr),
    .out(out), .out_q(out_q), .sel_toggles(sel_toggles), .b_cycles(b_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CNT_W-1:0] model_cnt(input logic [CNT_W-1:0] c,
                                                  input logic inc, input logic clear);
    if (clear) return 4'd0;
    if (inc && (c != CMAX)) return c + 4'd1;
    return c;
  endfunction

  // Reset pulse placed between clock edges; inputs parked at a quiet state.
  task automatic do_reset();
    @(negedge clk);
    sel = 1'b0;
    clr = 1'b0;
    #3 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; a = 1'b0; b = 1'b0; sel = 1'b0; clr = 1'b0;
    m_selq = 1'b0; m_tog = 4'd0; m_bc = 4'd0;

    tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b1, 1'b0, 1'b0, 1'b1};
    tt[2] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tt[3] = '{1'b1, 1'b1, 1'b1, 1'b1};
    tt[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tt[5] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tt[6] = '{1'b1, 1'b0, 1'b0, 1'b1};
    tt[7] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tt[8] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tt[9] = '{1'b1, 1'b1, 1'b1, 1'b1};

    fork
      // Reference model: push expected registered outputs at each rising edge.
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          m_selq = 1'b0; m_tog = 4'd0; m_bc = 4'd0;
          sb_q.delete();
        end else begin
          m_tog  = model_cnt(m_tog, sel != m_selq, clr);
          m_bc   = model_cnt(m_bc, sel, clr);
          m_selq = sel;
          sb_q.push_back(sb_rec_t'{out_q: (sel ? b : a), tog: m_tog, bc: m_bc});
        end
      end
      // Scoreboard: compare mid-cycle, well away from the active edge.
      forever begin
        @(negedge clk);
        if (rst_n && (sb_q.size() > 0)) begin
          check("sb_out_q", out_q, sb_q[0].out_q);
          check("sb_sel_toggles", sel_toggles, sb_q[0].tog);
          check("sb_b_cycles", b_cycles, sb_q[0].bc);
          void'(sb_q.pop_front());
        end
      end
    join_none

    // Reset state, and out stays live during reset
    #2;
    check("rst_out_q", out_q, 1'b0);
    check("rst_sel_toggles", sel_toggles, 4'd0);
    check("rst_b_cycles", b_cycles, 4'd0);
    check("rst_out", out, 1'b0);
    a = 1'b1;
    #1 check("rst_out_live", out, 1'b1);
    a = 1'b0;
    @(negedge clk);
    #3 rst_n = 1'b1;

    // Truth-table walk
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2 a = tt[i].a; b = tt[i].b; sel = tt[i].sel;
      #1 check("tt_out", out, tt[i].exp_out);
    end

    // Registered tap: out_q shows last cycle's out
    a = 1'b1; b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #2 sel = i[0];
      @(posedge clk);
      #1 check("tap_out_q", out_q, (i % 2 == 0) ? 1'b1 : 1'b0);
    end

    // Counters from reset with sel pattern 0,1,1,0,1, then a clr pulse
    do_reset();
    pat = 5'b10110;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #2 sel = pat[k];
    end
    @(posedge clk);
    #1 check("cnt_sel_toggles", sel_toggles, 4'd3);
    check("cnt_b_cycles", b_cycles, 4'd3);
    @(negedge clk);
    #2 clr = 1'b1;
    @(posedge clk);
    #1 check("clr_sel_toggles", sel_toggles, 4'd0);
    check("clr_b_cycles", b_cycles, 4'd0);
    @(negedge clk);
    #2 clr = 1'b0;

    // Saturation: 20 cycles of sel=1 on a 4-bit counter
    do_reset();
    sel = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("sat_b_cycles", b_cycles, 4'd15);
    check("sat_sel_toggles", sel_toggles, 4'd1);

    // Asynchronous reset between edges with counters nonzero
    @(negedge clk);
    a = 1'b1; b = 1'b0;
    #3 rst_n = 1'b0;
    #1 check("arst_out_q", out_q, 1'b0);
    check("arst_sel_toggles", sel_toggles, 4'd0);
    check("arst_b_cycles", b_cycles, 4'd0);
    check("arst_out_sel1", out, 1'b0);
    sel = 1'b0;
    #1 check("arst_out_sel0", out, 1'b1);
    @(posedge clk);
    #1 check("arst_hold_b_cycles", b_cycles, 4'd0);
    #3 rst_n = 1'b1;

    // Randomised compare, inputs changing after both edges
    for (int i = 0; i < 200; i++) begin
      if (i % 2 == 0) @(posedge clk);
      else @(negedge clk);
      #1;
      a   = 1'($urandom_range(0, 1));
      b   = 1'($urandom_range(0, 1));
      sel = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
      #1 check("rand_out", out, sel ? b : a);
    end

    clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
